jtopl_wrsched: RTL and testbench
================================

// Module: jtopl_wrsched
// PURPOSE
//  Write scheduler in front of jtopl_mmr. Arbitrates register writes from two requesters,
//  each a valid/ready port carrying {register, value}. Turns each accepted request into
//  the OPL bus sequence: address write (addr=0), wait, data write (addr=1), wait. Waits
//  are counted in cen ticks to honour YM3812 bus timing. Outputs drive jtopl_mmr write/addr/din.
// PARAMETERS
//  ADDR_WAIT  12  cen ticks required after an address write, before the data write
//  DATA_WAIT  84  cen ticks required after a data write, before the next request is accepted
//  CW          7  wait counter width; must satisfy 2**CW > max(ADDR_WAIT,DATA_WAIT)
//  SKIP_SAME   1  1: omit the address phase when the register equals the last one written
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  cen         in   1  clock enable used for wait counting (same cen as jtopl_mmr)
//  req0_valid  in   1  requester 0 has a write pending
//  req0_ready  out  1  requester 0 accepted this cycle when valid&ready
//  req0_reg    in   8  OPL register number
//  req0_val    in   8  value to write
//  req1_valid/req1_ready/req1_reg/req1_val   same as req0, for requester 1
//  opl_write   out  1  one-clk write strobe to jtopl_mmr.write
//  opl_addr    out  1  0=address cycle, 1=data cycle (jtopl_mmr.addr)
//  opl_din     out  8  bus data (jtopl_mmr.din)
//  busy        out  1  high whenever state != IDLE
//  gnt         out  1  requester that owns the current or last transfer
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; opl_write=0, opl_addr=0, opl_din=0, busy=0, gnt=1
//   (so req0 wins first); both ready=0; counter=0; last_reg invalid. A reset during any
//   phase aborts the sequence immediately. The half-written register is not replayed.
//  States: IDLE -> AWAIT -> DWAIT -> IDLE.
//  IDLE: ready is combinational. reqX_ready=1 only for the requester chosen by the arbiter,
//   and only while that requester's valid=1. Arbitration: if only one requester is valid,
//   it wins. If both are valid, the one != gnt wins (round robin).
//   On acceptance (cycle N): latch reg/val and set gnt.
//    - Normal case: in cycle N+1, opl_write=1, opl_addr=0, opl_din=reg. Counter loads
//      ADDR_WAIT and the state moves to AWAIT.
//    - SKIP_SAME && last_reg valid && reg==last_reg: in cycle N+1, opl_write=1,
//      opl_addr=1, opl_din=val. Counter loads DATA_WAIT and the state moves to DWAIT.
//  AWAIT: the counter decrements on each cen while nonzero. The cycle after it reads 0,
//   opl_write=1, opl_addr=1, opl_din=val. Counter loads DATA_WAIT and the state moves to
//   DWAIT. last_reg is updated and marked valid.
//  DWAIT: the counter decrements on cen. When it reads 0, the state returns to IDLE and
//   ready may assert in that same IDLE cycle.
//  opl_write is high for exactly one clk per phase. opl_addr and opl_din hold their last
//   values between strobes.
//  A wait parameter of 0 means the next phase follows on the very next clk.
//  With cen stuck low, the block holds its state indefinitely and no strobe is issued.
//  busy=1 from N+1 until the return to IDLE. No request is accepted while busy.
//  A requester may drop valid without a transfer. Its data is sampled only at the handshake.
// STRUCTURE
//  Shared header jtopl_wrsched.vh: state localparams (IDLE/AWAIT/DWAIT) and the default
//   YM3812 wait constants (12/84). jtopl_mmr instances and benches use the same constants.
//  Sub-module jtopl_wrsched_arb: 2-way round-robin arbiter (valid0, valid1, last gnt -> sel).
//   The wait counter and the FSM stay in this top.
// TESTING
//  1. Reset, then req0 {A0,55} -> cycle N+1 strobe addr=0 din=A0; 12 cen later strobe
//     addr=1 din=55; busy drops 84 cen after that.
//  2. req0 and req1 valid together from reset -> order req0,req1,req0,req1. Each ready
//     pulses once per transfer.
//  3. SKIP_SAME=1: two writes to reg B0 -> the second has a single strobe with addr=1 and
//     no address cycle. With SKIP_SAME=0 the second has both cycles.
//  4. cen low during AWAIT for 50 clk -> no strobe. The data strobe occurs 12 cen pulses
//     after the address strobe.
//  5. rst_n low mid-DWAIT -> all outputs 0 at once. After release, the first write to the
//     same reg issues the address cycle again.
//  6. ADDR_WAIT=0, DATA_WAIT=0 -> strobes on consecutive clks. A back-to-back request is
//     accepted in the cycle after the data strobe.

Source files
------------

// File: rtl/jtopl_wrsched_pkg.sv
// Shared definitions for the OPL write scheduler: FSM encodings, YM3812 bus
// timing defaults and the latched request record.
package jtopl_wrsched_pkg;

  // state    | meaning
  // ---------+-------------------------------------------------------------
  // ST_IDLE  | waiting for a request; ready is offered to the arbiter winner
  // ST_AWAIT | address written, counting cen ticks before the data write
  // ST_DWAIT | data written, counting cen ticks before the next request
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_AWAIT = 2'd1;
  localparam logic [1:0] ST_DWAIT = 2'd2;

  // YM3812 minimum spacing, in cen ticks, after an address / data write
  localparam int YM_ADDR_WAIT = 12;
  localparam int YM_DATA_WAIT = 84;

  typedef struct packed {
    logic [7:0] rg;
    logic [7:0] val;
  } wr_req_t;

endpackage

// File: rtl/jtopl_wrsched_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, and when both
// are valid the one that did not own the previous transfer wins.
module jtopl_wrsched_arb
  import jtopl_wrsched_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_gnt,
  output logic sel
);

  // Pick the winner from the current valids and the previous owner
  always_comb begin
    sel = 1'b0;
    if (valid0 && valid1) begin
      sel = ~last_gnt;
    end else if (valid1) begin
      sel = 1'b1;
    end
  end

endmodule

// File: rtl/jtopl_wrsched.sv
// Write scheduler in front of jtopl_mmr. Accepts {register, value} writes
// from two valid/ready requesters and replays each one as an OPL address
// write followed by a data write, spacing the strobes by cen-counted waits.
// Repeated writes to the same register may drop the address phase.
module jtopl_wrsched
  import jtopl_wrsched_pkg::*;
#(
  parameter int ADDR_WAIT = YM_ADDR_WAIT,
  parameter int DATA_WAIT = YM_DATA_WAIT,
  parameter int CW        = 7,
  parameter int SKIP_SAME = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_val,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_val,
  output logic       opl_write,
  output logic       opl_addr,
  output logic [7:0] opl_din,
  output logic       busy,
  output logic       gnt
);

  localparam logic [CW-1:0] ADDR_LD = CW'(ADDR_WAIT);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_WAIT);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  wr_req_t       cur_q;
  wr_req_t       in_req;
  logic [7:0]    last_reg;
  logic          last_ok;
  logic          sel;
  logic          idle;
  logic          accept;
  logic          skip;
  logic          cnt_zero;

  jtopl_wrsched_arb u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last_gnt (gnt),
    .sel      (sel)
  );

  // Handshake: ready only in IDLE, only to the arbiter winner, and never
  // while reset is asserted, so nothing can be accepted into a held block
  always_comb begin
    idle       = (state == ST_IDLE);
    req0_ready = rst_n & idle & req0_valid & ~sel;
    req1_ready = rst_n & idle & req1_valid & sel;
    accept     = req0_ready | req1_ready;
    in_req.rg  = sel ? req1_reg : req0_reg;
    in_req.val = sel ? req1_val : req0_val;
    skip       = (SKIP_SAME != 0) && last_ok && (in_req.rg == last_reg);
    cnt_zero   = (cnt == '0);
  end

  assign busy = (state != ST_IDLE);

  // Sequencer: issues the bus strobes and runs the shared wait counter.
  // A phase boundary is taken as soon as the counter reads zero, without
  // waiting for cen, so a zero wait moves on in the very next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_q     <= '0;
      last_reg  <= '0;
      last_ok   <= 1'b0;
      gnt       <= 1'b1;
      opl_write <= 1'b0;
      opl_addr  <= 1'b0;
      opl_din   <= '0;
    end else begin
      opl_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_q     <= in_req;
            gnt       <= sel;
            opl_write <= 1'b1;
            if (skip) begin
              opl_addr <= 1'b1;
              opl_din  <= in_req.val;
              cnt      <= DATA_LD;
              state    <= ST_DWAIT;
            end else begin
              opl_addr <= 1'b0;
              opl_din  <= in_req.rg;
              cnt      <= ADDR_LD;
              state    <= ST_AWAIT;
            end
          end
        end
        ST_AWAIT: begin
          if (cnt_zero) begin
            opl_write <= 1'b1;
            opl_addr  <= 1'b1;
            opl_din   <= cur_q.val;
            cnt       <= DATA_LD;
            last_reg  <= cur_q.rg;
            last_ok   <= 1'b1;
            state     <= ST_DWAIT;
          end else if (cen) begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DWAIT: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
          end else if (cen) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Directed bench for jtopl_wrsched. One instance uses the YM3812 defaults,
// a second uses zero waits with same-register skipping disabled.
module tb_jtopl_wrsched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen = 1'b1;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_reg = '0, req0_val = '0, req1_reg = '0, req1_val = '0;
  logic       opl_write, opl_addr, busy, gnt;
  logic [7:0] opl_din;

  logic       f_req0_valid = 1'b0, f_req1_valid = 1'b0;
  logic       f_req0_ready, f_req1_ready;
  logic [7:0] f_req0_reg = '0, f_req0_val = '0, f_req1_reg = '0, f_req1_val = '0;
  logic       f_opl_write, f_opl_addr, f_busy, f_gnt;
  logic [7:0] f_opl_din;

  typedef struct { int cyc; logic addr; logic [7:0] din; } strb_t;
  typedef struct { int cyc; int who; logic [7:0] rg; logic [7:0] val; } acc_t;

  strb_t m_str[$];
  strb_t f_str[$];
  acc_t  m_acc[$];
  acc_t  f_acc[$];

  int cyc_n = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtopl_wrsched u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_val(req0_val),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_val(req1_val),
    .opl_write(opl_write), .opl_addr(opl_addr), .opl_din(opl_din), .busy(busy), .gnt(gnt)
  );

  jtopl_wrsched #(.ADDR_WAIT(0), .DATA_WAIT(0), .CW(7), .SKIP_SAME(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_reg(f_req0_reg), .req0_val(f_req0_val),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_reg(f_req1_reg), .req1_val(f_req1_val),
    .opl_write(f_opl_write), .opl_addr(f_opl_addr), .opl_din(f_opl_din), .busy(f_busy), .gnt(f_gnt)
  );

  // Handshake recorder; cyc_n is the number of the cycle that just ended
  always @(posedge clk) begin
    acc_t a;
    if (req0_valid && req0_ready) begin
      a.cyc = cyc_n; a.who = 0; a.rg = req0_reg; a.val = req0_val; m_acc.push_back(a);
    end
    if (req1_valid && req1_ready) begin
      a.cyc = cyc_n; a.who = 1; a.rg = req1_reg; a.val = req1_val; m_acc.push_back(a);
    end
    if (f_req0_valid && f_req0_ready) begin
      a.cyc = cyc_n; a.who = 0; a.rg = f_req0_reg; a.val = f_req0_val; f_acc.push_back(a);
    end
    cyc_n = cyc_n + 1;
  end

  // Strobe recorder, sampled mid-cycle
  always @(negedge clk) begin
    strb_t s;
    if (opl_write) begin
      s.cyc = cyc_n; s.addr = opl_addr; s.din = opl_din; m_str.push_back(s);
    end
    if (f_opl_write) begin
      s.cyc = cyc_n; s.addr = f_opl_addr; s.din = f_opl_din; f_str.push_back(s);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cen = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_str.delete(); f_str.delete(); m_acc.delete(); f_acc.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) @(negedge clk);
  endtask

  task automatic wait_acc(input bit fast, input int n, input int limit, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < limit) begin
      if ((fast ? f_acc.size() : m_acc.size()) >= n) ok = 1'b1;
      else begin @(negedge clk); i++; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({opl_write, opl_addr, opl_din, busy, gnt} !== 12'b0_0_00000000_0_1) begin
      n_fail++; $display("FAIL reset_outputs: got w=%b a=%b d=%h busy=%b gnt=%b, want 0 0 00 0 1",
                         opl_write, opl_addr, opl_din, busy, gnt);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b%b, want 00", req0_ready, req1_ready);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int n0;
    do_reset();
    req0_reg = 8'hA0; req0_val = 8'h55; req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL basic_ready: got %b%b, want 10", req0_ready, req1_ready);
    end
    n0 = cyc_n;
    @(negedge clk);
    req0_valid = 1'b0; req0_reg = 8'hFF; req0_val = 8'hFF;
    n_checks++;
    if ({opl_write, opl_addr, opl_din, busy, gnt} !== {1'b1, 1'b0, 8'hA0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_addr_strobe: got w=%b a=%b d=%h busy=%b gnt=%b, want 1 0 a0 1 0",
                         opl_write, opl_addr, opl_din, busy, gnt);
    end
    @(negedge clk);
    n_checks++;
    if ({opl_write, opl_addr, opl_din} !== {1'b0, 1'b0, 8'hA0}) begin
      n_fail++; $display("FAIL basic_hold: got w=%b a=%b d=%h, want 0 0 a0", opl_write, opl_addr, opl_din);
    end
    wait_until(n0 + 98);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_last: got %b, want 1", busy); end
    wait_until(n0 + 99);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b, want 0", busy); end
    n_checks++;
    if (m_str.size() !== 2) begin
      n_fail++; $display("FAIL basic_strobe_count: got %0d, want 2", m_str.size());
    end else begin
      n_checks++;
      if (m_str[1].cyc !== n0 + 14 || m_str[1].addr !== 1'b1 || m_str[1].din !== 8'h55) begin
        n_fail++; $display("FAIL basic_data_strobe: got cyc=+%0d a=%b d=%h, want +14 1 55",
                           m_str[1].cyc - n0, m_str[1].addr, m_str[1].din);
      end
    end
  endtask

  task automatic test_round_robin();
    int  exp_who[4] = '{0, 1, 0, 1};
    bit  ok;
    do_reset();
    req0_reg = 8'h10; req0_val = 8'h01; req1_reg = 8'h20; req1_val = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_first_ready: got %b%b, want 10", req0_ready, req1_ready);
    end
    wait_acc(1'b0, 4, 600, ok);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d accepts, want 4", m_acc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (m_acc[i].who !== exp_who[i] || m_acc[i].rg !== (exp_who[i] == 0 ? 8'h10 : 8'h20)) begin
          n_fail++; $display("FAIL rr_order[%0d]: got req%0d reg=%h, want req%0d", i, m_acc[i].who,
                             m_acc[i].rg, exp_who[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (m_acc[i].cyc - m_acc[i-1].cyc !== 99) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d, want 99", i, m_acc[i].cyc - m_acc[i-1].cyc);
        end
      end
      wait_until(m_acc[3].cyc + 100);
      n_checks++;
      if (m_acc.size() !== 4 || m_str.size() !== 8 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rr_totals: got accepts=%0d strobes=%0d busy=%b, want 4 8 0",
                           m_acc.size(), m_str.size(), busy);
      end
    end
  endtask

  task automatic test_skip_same();
    bit ok;
    int n2;
    do_reset();
    req0_reg = 8'hB0; req0_val = 8'h11; req0_valid = 1'b1;
    wait_acc(1'b0, 1, 10, ok);
    req0_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL skip_first_timeout: got 0 accepts, want 1"); end
    else begin
      wait_until(m_acc[0].cyc + 99);
      req0_val = 8'h22; req0_valid = 1'b1;
      wait_acc(1'b0, 2, 10, ok);
      req0_valid = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL skip_second_timeout: got %0d accepts, want 2", m_acc.size()); end
      else begin
        n2 = m_acc[1].cyc;
        wait_until(n2 + 85);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL skip_busy_last: got %b, want 1", busy); end
        wait_until(n2 + 86);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL skip_busy_drop: got %b, want 0", busy); end
        n_checks++;
        if (m_str.size() !== 3) begin
          n_fail++; $display("FAIL skip_strobe_count: got %0d, want 3", m_str.size());
        end else begin
          n_checks++;
          if (m_str[2].cyc !== n2 + 1 || m_str[2].addr !== 1'b1 || m_str[2].din !== 8'h22) begin
            n_fail++; $display("FAIL skip_data_only: got cyc=+%0d a=%b d=%h, want +1 1 22",
                               m_str[2].cyc - n2, m_str[2].addr, m_str[2].din);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         off[4] = '{1, 2, 4, 5};
    logic       ea[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed[4]  = '{8'hB0, 8'h11, 8'hB0, 8'h22};
    int n0;
    bit ok;
    do_reset();
    f_req0_reg = 8'hB0; f_req0_val = 8'h11; f_req0_valid = 1'b1;
    #1;
    n_checks++;
    if (f_req0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, want 1", f_req0_ready); end
    n0 = cyc_n;
    wait_acc(1'b1, 1, 10, ok);
    f_req0_val = 8'h22;
    wait_acc(1'b1, 2, 10, ok);
    f_req0_valid = 1'b0;
    wait_until(n0 + 8);
    n_checks++;
    if (f_acc.size() !== 2) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d, want 2", f_acc.size());
    end else begin
      n_checks++;
      if (f_acc[1].cyc !== n0 + 3 || f_acc[1].val !== 8'h22) begin
        n_fail++; $display("FAIL b2b_second_accept: got cyc=+%0d val=%h, want +3 22",
                           f_acc[1].cyc - n0, f_acc[1].val);
      end
    end
    n_checks++;
    if (f_str.size() !== 4) begin
      n_fail++; $display("FAIL b2b_strobe_count: got %0d, want 4", f_str.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (f_str[i].cyc !== n0 + off[i] || f_str[i].addr !== ea[i] || f_str[i].din !== ed[i]) begin
          n_fail++; $display("FAIL b2b_strobe[%0d]: got cyc=+%0d a=%b d=%h, want +%0d %b %h", i,
                             f_str[i].cyc - n0, f_str[i].addr, f_str[i].din, off[i], ea[i], ed[i]);
        end
      end
    end
    n_checks++;
    if (f_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b, want 0", f_busy); end
  endtask

  task automatic test_cen_stall();
    int n0;
    int seen = 0;
    do_reset();
    req0_reg = 8'hC0; req0_val = 8'h77; req0_valid = 1'b1;
    n0 = cyc_n;
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++;
    if ({opl_write, opl_addr, opl_din} !== {1'b1, 1'b0, 8'hC0}) begin
      n_fail++; $display("FAIL stall_addr_strobe: got w=%b a=%b d=%h, want 1 0 c0", opl_write, opl_addr, opl_din);
    end
    wait_until(n0 + 6);
    cen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (opl_write || !busy) seen++;
    end
    cen = 1'b1;
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL stall_quiet: got %0d active cycles, want 0", seen); end
    wait_until(n0 + 63);
    n_checks++;
    if (opl_write !== 1'b0) begin n_fail++; $display("FAIL stall_early: got w=%b, want 0", opl_write); end
    wait_until(n0 + 64);
    n_checks++;
    if ({opl_write, opl_addr, opl_din} !== {1'b1, 1'b1, 8'h77}) begin
      n_fail++; $display("FAIL stall_data_strobe: got w=%b a=%b d=%h, want 1 1 77", opl_write, opl_addr, opl_din);
    end
    wait_until(n0 + 64 + 85);
    n_checks++;
    if (busy !== 1'b0 || m_str.size() !== 2) begin
      n_fail++; $display("FAIL stall_end: got busy=%b strobes=%0d, want 0 2", busy, m_str.size());
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    req0_reg = 8'hD0; req0_val = 8'h44; req0_valid = 1'b1;
    n0 = cyc_n;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_until(n0 + 40);
    n_checks++;
    if ({busy, opl_addr, opl_din} !== {1'b1, 1'b1, 8'h44}) begin
      n_fail++; $display("FAIL mid_precond: got busy=%b a=%b d=%h, want 1 1 44", busy, opl_addr, opl_din);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({opl_write, opl_addr, opl_din, busy, gnt} !== 12'b0_0_00000000_0_1) begin
      n_fail++; $display("FAIL mid_reset_outputs: got w=%b a=%b d=%h busy=%b gnt=%b, want 0 0 00 0 1",
                         opl_write, opl_addr, opl_din, busy, gnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_str.delete(); m_acc.delete();
    repeat (20) @(negedge clk);
    n_checks++;
    if (m_str.size() !== 0) begin n_fail++; $display("FAIL mid_no_replay: got %0d strobes, want 0", m_str.size()); end
    req0_val = 8'h46; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++;
    if ({opl_write, opl_addr, opl_din} !== {1'b1, 1'b0, 8'hD0}) begin
      n_fail++; $display("FAIL mid_addr_again: got w=%b a=%b d=%h, want 1 0 d0", opl_write, opl_addr, opl_din);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_skip_same();
    test_back_to_back();
    test_cen_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
